// File: rtl/game_logic_classic_multi_if.sv
// rtl/game_logic_classic_multi_if.sv - classic-mode game controller signal bundle
interface game_logic_classic_multi_if #(
  parameter int N_ENEMY = 4,
  parameter int SCORE_W = 5,
  parameter int LED_W   = 16,
  parameter int SEG_W   = 16,
  parameter int HP_W    = 4
);
  logic                       enable_game_classic;
  logic                       mytank_state;
  logic [N_ENEMY*SCORE_W-1:0] scores;
  logic [SEG_W-1:0]           seg_classic;
  logic [LED_W-1:0]           led_classic;
  logic [HP_W-1:0]            hp_value;
  logic                       gameover_classic;

  // Game objects and mode control drive the inputs, the output mux reads the results
  modport master (
    output enable_game_classic,
    output mytank_state,
    output scores,
    input  seg_classic,
    input  led_classic,
    input  hp_value,
    input  gameover_classic
  );

  // The controller itself
  modport slave (
    input  enable_game_classic,
    input  mytank_state,
    input  scores,
    output seg_classic,
    output led_classic,
    output hp_value,
    output gameover_classic
  );
endinterface

// File: rtl/game_logic_classic_multi.sv
// rtl/game_logic_classic_multi.sv - classic-mode score, HP and game-over controller
module game_logic_classic_multi #(
  parameter int N_ENEMY    = 4,
  parameter int SCORE_W    = 5,
  parameter int HP_MAX     = 8,
  parameter int HP_INIT    = 8,
  parameter int BONUS_STEP = 10,
  parameter int LED_W      = 16,
  parameter int SEG_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  game_logic_classic_multi_if.slave    bus
);
  localparam int SUM_W = SCORE_W + $clog2(N_ENEMY);
  localparam int HP_W  = $clog2(HP_MAX + 1);
  localparam int THR_W = SUM_W + 1;

  localparam logic [THR_W-1:0] THR_MAX   = '1;
  localparam logic [THR_W-1:0] THR_STEP  = THR_W'(BONUS_STEP);
  localparam logic [HP_W-1:0]  HP_INIT_V = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]  HP_MAX_V  = HP_W'(HP_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t             state;
  logic [HP_W-1:0]    hp;
  logic [THR_W-1:0]   next_thr;
  logic               tank_d;
  logic [SUM_W-1:0]   score_total;
  logic [SEG_W-1:0]   seg_q;
  logic [LED_W-1:0]   led_q;
  logic               gameover_q;

  logic [SUM_W-1:0]   sum_comb;
  logic               hit;
  logic               bonus;
  logic [HP_W-1:0]    hp_next;
  logic [THR_W:0]     thr_sum;
  logic [THR_W-1:0]   thr_adv;

  // HP bar: the top n LEDs lit, MSB first
  function automatic logic [LED_W-1:0] bar(input logic [HP_W-1:0] n);
    logic [LED_W-1:0] b;
    b = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (i < int'(n)) b[LED_W-1-i] = 1'b1;
    end
    return b;
  endfunction

  // Sum of all enemy kill scores; SUM_W is wide enough that this never wraps
  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      sum_comb = sum_comb + SUM_W'(bus.scores[i*SCORE_W +: SCORE_W]);
    end
  end

  // Hit on the falling edge of the alive flag, bonus when the total reaches the threshold
  always_comb begin
    hit   = tank_d & ~bus.mytank_state;
    bonus = (state == PLAY) && ({1'b0, score_total} >= next_thr);
  end

  // Threshold advance saturates so a runaway threshold never wraps back into range
  always_comb begin
    thr_sum = {1'b0, next_thr} + {1'b0, THR_STEP};
    thr_adv = thr_sum[THR_W] ? THR_MAX : thr_sum[THR_W-1:0];
  end

  // Next HP: a simultaneous hit and bonus cancel; a bonus at the ceiling is dropped
  always_comb begin
    hp_next = hp;
    if (bonus && !hit) begin
      if (hp != HP_MAX_V) hp_next = hp + HP_W'(1);
    end else if (hit && !bonus) begin
      hp_next = hp - HP_W'(1);
    end
  end

  // Game FSM with score pipeline and registered display/LED/game-over outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hp          <= HP_INIT_V;
      next_thr    <= THR_STEP;
      tank_d      <= 1'b1;
      score_total <= '0;
      seg_q       <= '0;
      led_q       <= bar(HP_INIT_V);
      gameover_q  <= 1'b0;
    end else begin
      tank_d      <= bus.mytank_state;
      score_total <= sum_comb;
      seg_q       <= SEG_W'(score_total);
      if (!bus.enable_game_classic) begin
        state      <= IDLE;
        hp         <= HP_INIT_V;
        next_thr   <= THR_STEP;
        led_q      <= bar(HP_INIT_V);
        gameover_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A hit sampled on the start edge is deliberately not applied
            state      <= PLAY;
            hp         <= HP_INIT_V;
            next_thr   <= THR_STEP;
            led_q      <= bar(HP_INIT_V);
            gameover_q <= 1'b0;
          end
          PLAY: begin
            hp    <= hp_next;
            led_q <= bar(hp_next);
            if (bonus) next_thr <= thr_adv;
            if (hp_next == '0) begin
              state      <= OVER;
              gameover_q <= 1'b1;
            end
          end
          OVER: begin
            hp         <= '0;
            led_q      <= '0;
            gameover_q <= 1'b1;
          end
          default: begin
            state      <= IDLE;
            hp         <= HP_INIT_V;
            next_thr   <= THR_STEP;
            led_q      <= bar(HP_INIT_V);
            gameover_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.seg_classic      = seg_q;
  assign bus.led_classic      = led_q;
  assign bus.hp_value         = hp;
  assign bus.gameover_classic = gameover_q;

endmodule

// File: doc/game_logic_classic_multi.md
# game_logic_classic_multi

Parametrised classic-mode game controller: sums the kill scores of N enemy channels, maintains player HP with hit decrement and score-threshold bonus lives, and drives the score display value, an HP LED bar and the game-over flag. It sits between the enemy/tank objects and the seg/LED output mux, as the classic-mode logic block.

## Interface
- N_ENEMY, 4, number of enemy score channels
- SCORE_W, 5, width of each per-enemy score
- HP_MAX, 8, HP ceiling; bonus lives saturate here
- HP_INIT, 8, HP loaded at reset, in IDLE and on game start; 1 ≤ HP_INIT ≤ HP_MAX
- BONUS_STEP, 10, score interval between bonus lives; ≥ 1
- LED_W, 16, LED bar width; LED_W ≥ HP_MAX
- SEG_W, 16, display value width; SEG_W ≥ SUM_W
- SUM_W is derived, not overridable: SCORE_W + clog2(N_ENEMY)

- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable_game_classic  in  1  level; high = classic game running
- mytank_state  in  1  level; 1 = player tank alive; a 1→0 transition is one hit. Synchronous to clk.
- scores  in  N_ENEMY*SCORE_W  packed per-enemy scores; channel i is scores[i*SCORE_W +: SCORE_W]
- seg_classic  out  SEG_W  total score, zero-extended
- led_classic  out  LED_W  HP bar: top hp bits set, MSB first
- hp_value  out  clog2(HP_MAX+1)  current HP
- gameover_classic  out  1  high while in OVER

## Operation
- FSM states: IDLE, PLAY, OVER.
  - IDLE → PLAY when enable_game_classic is sampled high. On entry, hp = HP_INIT and next_thr = BONUS_STEP.
  - PLAY → OVER when hp_next == 0.
  - Any state → IDLE when enable_game_classic is sampled low. hp = HP_INIT, gameover_classic = 0.
  - OVER holds until enable_game_classic goes low. hp is held at 0 and hits and bonuses are ignored.
- score_total (SUM_W bits) <= sum of all channels every cycle, in every state. The sum never overflows at SUM_W.
- Hit detection:
  - tank_d <= mytank_state every cycle.
  - hit = tank_d & ~mytank_state, evaluated combinationally in the same cycle.
  - mytank_state held low produces one hit only.
- Bonus:
  - bonus = (score_total >= next_thr) in PLAY.
  - On each bonus, next_thr += BONUS_STEP.
  - At most one bonus per cycle. Large score jumps are caught up over consecutive cycles.
  - next_thr is SUM_W+1 bits and saturates at all-ones. Once next_thr exceeds the maximum possible sum, no further bonuses occur.
- HP update in PLAY: hp_next = min(hp + bonus − hit, HP_MAX).
  - Hit and bonus in the same cycle leave hp unchanged, including at HP_MAX. The threshold still advances.
  - A bonus at HP_MAX is consumed; the extra life is not banked.
- led_classic = {hp ones, zeros}, MSB-aligned, computed from hp_next and registered. The whole bar is zero in OVER.
- seg_classic <= zero-extended score_total.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - state IDLE, hp = HP_INIT, next_thr = BONUS_STEP
  - tank_d = 1, score_total = 0, seg_classic = 0
  - led_classic = bar(HP_INIT), gameover_classic = 0
- Hit latency: hp_value and led_classic change at the first rising edge that samples mytank_state low.
- Score latency: score_total updates one edge after scores change.
  - seg_classic updates one edge after score_total (2 edges total).
  - A resulting bonus is applied to hp one edge after score_total (2 edges total).
- Game over: gameover_classic rises at the same edge at which hp_value becomes 0.
- Enable low: IDLE values appear at the next edge. gameover_classic falls at that same edge.
- Enable high in IDLE: PLAY starts at the next edge. A hit sampled in that same cycle is ignored.
- Reset asserted mid-game: all outputs take their reset values immediately, with no clock edge needed.

## Test plan
- Reset, then enable = 1, then three single-cycle low pulses on mytank_state → hp_value 8→5, led_classic = 16'hF800, gameover_classic stays 0.
- In PLAY, hold mytank_state low for 20 cycles → exactly one decrement (hp_value 8→7).
- Scores step from total 0 to 25 in one cycle with hp = 5:
  - hp goes 6 then 7 on consecutive edges, the first of those 2 edges after the input change.
  - next_thr ends at 30.
  - seg_classic = 25.
- At hp = HP_MAX, raise the score past a threshold while a hit occurs in the same cycle → hp_value stays 8 and the threshold advances.
- At hp = 1 apply a hit → hp_value = 0, led_classic = 0 and gameover_classic = 1 at the same edge. Further hits and bonuses leave them unchanged. Enable low → gameover_classic = 0 and hp_value = 8 at the next edge.
- Assert rst_n low between clock edges mid-game → all outputs return to their reset values immediately. Repeat with N_ENEMY = 8 and SCORE_W = 6 (all channels = 63, sum 504) → seg_classic = 504 with no overflow.
